// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: registered MEM stage between EX and WB, fronting the data bus.
// Steers byte lanes, extends loads, and flags misalignment, bus errors and response timeouts.
module lsu_mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_result,
  input  logic [XLEN-1:0]   i_data_store,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_func3,
  input  logic [4:0]        i_rd,
  output logic              o_d_valid,
  input  logic              i_d_ready,
  output logic              o_wr_en,
  output logic [XLEN/8-1:0] o_sel,
  output logic [XLEN-1:0]   o_daddr,
  output logic [XLEN-1:0]   o_write_data,
  input  logic              i_d_rvalid,
  input  logic [XLEN-1:0]   i_read_data,
  input  logic              i_error,
  output logic              o_wb_valid,
  output logic              o_wb_we,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [6:0]        o_opcode,
  output logic              o_exc,
  output logic [1:0]        o_exc_cause,
  output logic [4:0]        o_fwd_rd,
  output logic              o_fwd_busy
);
  // state | meaning
  // IDLE  | waiting for EX, o_ready high
  // REQ   | bus request presented until i_d_ready
  // WAIT  | request taken, waiting for response or timeout
  // RESP  | one-cycle write-back pulse

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;

  localparam logic [1:0] CAUSE_LMIS  = 2'd0;
  localparam logic [1:0] CAUSE_SMIS  = 2'd1;
  localparam logic [1:0] CAUSE_FAULT = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [XLEN-1:0] r_addr;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_is_ld;

  logic            in_is_ld;
  logic            in_is_st;
  logic            in_misal;
  logic [OFS-1:0]  in_off;
  logic [NB-1:0]   in_bm;
  logic [NB-1:0]   in_sel;
  logic [XLEN-1:0] in_dmask;
  logic [XLEN-1:0] in_wdata;
  logic [XLEN-1:0] in_nonmem;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;
  logic            ld_ext;

  always_comb begin
    in_is_ld  = (i_opcode == OP_LD);
    in_is_st  = (i_opcode == OP_S);
    in_off    = i_result[OFS-1:0];
    in_misal  = ((int'(in_off) & ((1 << i_func3[1:0]) - 1)) != 0);
    // dword and LWU only exist on RV64
    if (XLEN == 32 && i_func3[1:0] == 2'b11) in_misal = 1'b1;
    if (XLEN == 32 && in_is_ld && i_func3 == 3'b110) in_misal = 1'b1;
    in_dmask  = '0;
    in_bm     = '0;
    for (int i = 0; i < XLEN; i++) in_dmask[i] = (i < (8 << i_func3[1:0]));
    for (int i = 0; i < NB; i++) in_bm[i] = (i < (1 << i_func3[1:0]));
    in_sel    = in_bm << in_off;
    in_wdata  = (i_data_store & in_dmask) << {in_off, 3'b000};
    in_nonmem = (i_opcode == OP_J || i_opcode == OP_JR) ? i_pc + XLEN'(4) : i_result;
  end

  always_comb begin
    ld_shift = i_read_data >> {r_addr[OFS-1:0], 3'b000};
    ld_ext   = 1'b0;
    for (int i = 0; i < XLEN; i++)
      if (i == (8 << r_size) - 1) ld_ext = ~r_uns & ld_shift[i];
    ld_data  = ld_shift;
    for (int i = 0; i < XLEN; i++)
      if (i >= (8 << r_size)) ld_data[i] = ld_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmr          <= '0;
      r_addr       <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_is_ld      <= 1'b0;
      o_ready      <= 1'b0;
      o_d_valid    <= 1'b0;
      o_wr_en      <= 1'b0;
      o_sel        <= '0;
      o_daddr      <= '0;
      o_write_data <= '0;
      o_wb_valid   <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_rd      <= '0;
      o_wb_data    <= '0;
      o_opcode     <= '0;
      o_exc        <= 1'b0;
      o_exc_cause  <= '0;
      o_fwd_rd     <= '0;
      o_fwd_busy   <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            o_ready  <= 1'b0;
            o_opcode <= i_opcode;
            o_wb_rd  <= i_rd;
            r_addr   <= i_result;
            r_size   <= i_func3[1:0];
            r_uns    <= i_func3[2];
            r_is_ld  <= in_is_ld;
            if (!(in_is_ld || in_is_st)) begin
              state       <= RESP;
              o_wb_valid  <= 1'b1;
              o_wb_we     <= (i_rd != 5'd0);
              o_wb_data   <= in_nonmem;
              o_exc       <= 1'b0;
              o_exc_cause <= '0;
            end else if (in_misal) begin
              state       <= RESP;
              o_wb_valid  <= 1'b1;
              o_wb_we     <= 1'b0;
              o_wb_data   <= i_result;
              o_exc       <= 1'b1;
              o_exc_cause <= in_is_st ? CAUSE_SMIS : CAUSE_LMIS;
            end else begin
              state        <= REQ;
              o_d_valid    <= 1'b1;
              o_wr_en      <= in_is_st;
              o_sel        <= in_sel;
              o_daddr      <= {i_result[XLEN-1:OFS], {OFS{1'b0}}};
              o_write_data <= in_is_st ? in_wdata : '0;
              o_fwd_busy   <= in_is_ld;
              o_fwd_rd     <= in_is_ld ? i_rd : 5'd0;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        REQ: begin
          if (i_d_ready) begin
            state     <= WAIT;
            o_d_valid <= 1'b0;
            tmr       <= TW'(TIMEOUT);
          end
        end
        WAIT: begin
          if (i_d_rvalid) begin
            state      <= RESP;
            o_wb_valid <= 1'b1;
            o_fwd_busy <= 1'b0;
            o_fwd_rd   <= '0;
            if (i_error) begin
              o_wb_we     <= 1'b0;
              o_wb_data   <= r_addr;
              o_exc       <= 1'b1;
              o_exc_cause <= CAUSE_FAULT;
            end else begin
              o_wb_we     <= r_is_ld && (o_wb_rd != 5'd0);
              o_wb_data   <= r_is_ld ? ld_data : '0;
              o_exc       <= 1'b0;
              o_exc_cause <= '0;
            end
          end else if (TIMEOUT != 0 && tmr == TW'(1)) begin
            // terminal count: TIMEOUT cycles spent in WAIT
            state       <= RESP;
            o_wb_valid  <= 1'b1;
            o_fwd_busy  <= 1'b0;
            o_fwd_rd    <= '0;
            o_wb_we     <= 1'b0;
            o_wb_data   <= r_addr;
            o_exc       <= 1'b1;
            o_exc_cause <= CAUSE_FAULT;
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a 32-bit instance (TIMEOUT 4) and a 64-bit instance share stimulus.
// Expected write-backs are queued when an instruction is issued and popped when its pulse appears.
`timescale 1ns/1ps
module tb_lsu_mem_stage;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        exc;
    logic [1:0]  cause;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v32 = 1'b0, v64 = 1'b0;
  logic [63:0] result = '0, store = '0, pc = '0, rdata = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [4:0]  rd = '0;
  logic        d_ready = 1'b0, d_rvalid = 1'b0, d_error = 1'b0;

  logic        r32, dv32, we32, wbv32, wbwe32, exc32, fbusy32;
  logic [3:0]  sel32;
  logic [31:0] daddr32, wdata32, wbd32;
  logic [4:0]  wbrd32, frd32;
  logic [6:0]  opc32;
  logic [1:0]  cause32;

  logic        r64, dv64, we64, wbv64, wbwe64, exc64, fbusy64;
  logic [7:0]  sel64;
  logic [63:0] daddr64, wdata64, wbd64;
  logic [4:0]  wbrd64, frd64;
  logic [6:0]  opc64;
  logic [1:0]  cause64;

  wb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst), .i_valid(v32), .o_ready(r32),
    .i_result(result[31:0]), .i_data_store(store[31:0]), .i_pc(pc[31:0]),
    .i_opcode(opcode), .i_func3(func3), .i_rd(rd),
    .o_d_valid(dv32), .i_d_ready(d_ready), .o_wr_en(we32), .o_sel(sel32),
    .o_daddr(daddr32), .o_write_data(wdata32), .i_d_rvalid(d_rvalid),
    .i_read_data(rdata[31:0]), .i_error(d_error), .o_wb_valid(wbv32),
    .o_wb_we(wbwe32), .o_wb_rd(wbrd32), .o_wb_data(wbd32), .o_opcode(opc32),
    .o_exc(exc32), .o_exc_cause(cause32), .o_fwd_rd(frd32), .o_fwd_busy(fbusy32)
  );

  lsu_mem_stage #(.XLEN(64), .TIMEOUT(8)) u_dut64 (
    .clk(clk), .rst(rst), .i_valid(v64), .o_ready(r64),
    .i_result(result), .i_data_store(store), .i_pc(pc),
    .i_opcode(opcode), .i_func3(func3), .i_rd(rd),
    .o_d_valid(dv64), .i_d_ready(d_ready), .o_wr_en(we64), .o_sel(sel64),
    .o_daddr(daddr64), .o_write_data(wdata64), .i_d_rvalid(d_rvalid),
    .i_read_data(rdata), .i_error(d_error), .o_wb_valid(wbv64),
    .o_wb_we(wbwe64), .o_wb_rd(wbrd64), .o_wb_data(wbd64), .o_opcode(opc64),
    .o_exc(exc64), .o_exc_cause(cause64), .o_fwd_rd(frd64), .o_fwd_busy(fbusy64)
  );

  function automatic wb_t mk(input logic we, input logic [4:0] r, input logic [63:0] d,
                             input logic e, input logic [1:0] c);
    return {we, r, d, e, c};
  endfunction

  // Waits for o_ready, presents one instruction, returns at the negedge of cycle T+1.
  task automatic send(input bit w64, input logic [6:0] op, input logic [2:0] f3,
                      input logic [63:0] res, input logic [63:0] st, input logic [63:0] p,
                      input logic [4:0] r);
    int n = 0;
    while (!(w64 ? r64 : r32) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: o_ready still %b after %0d cycles, required 1", w64 ? r64 : r32, n);
    end
    opcode = op; func3 = f3; result = res; store = st; pc = p; rd = r;
    if (w64) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  // Captures the next write-back pulse; lat = cycle index after the accept edge, -1 on expiry.
  task automatic wait_wb(input bit w64, input int start, output wb_t got, output int lat);
    lat = start;
    got = 'x;
    while (!(w64 ? wbv64 : wbv32)) begin
      if (lat >= start + 40) begin
        lat = -1;
        return;
      end
      @(negedge clk);
      lat++;
    end
    if (w64) got = {wbwe64, wbrd64, wbd64, exc64, cause64};
    else     got = {wbwe32, wbrd32, {32'b0, wbd32}, exc32, cause32};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({r32, dv32, wbv32, fbusy32, r64, dv64, wbv64, fbusy64} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {r32, dv32, wbv32, fbusy32, r64, dv64, wbv64, fbusy64});
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (r32 !== 1'b1 || r64 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b%b, required 11", r32, r64);
    end
  endtask

  task automatic test_alu();
    wb_t got, exp;
    int  lat;
    sb.push_back(mk(1'b1, 5'd5, 64'h1234_5678, 1'b0, 2'd0));
    send(0, OP_ALU, 3'b000, 64'h1234_5678, 64'h0, 64'h40, 5'd5);
    n_vec++;
    if (dv32 !== 1'b0) begin n_err++; $display("FAIL alu_no_bus: o_d_valid %b, required 0", dv32); end
    wait_wb(0, 1, got, lat);
    exp = sb.pop_front();
    n_vec += 3;
    if (lat != 1) begin n_err++; $display("FAIL alu_latency: wb at T+%0d, required T+1", lat); end
    if (got !== exp) begin n_err++; $display("FAIL alu_wb: got %h, required %h", got, exp); end
    if (opc32 !== OP_ALU) begin n_err++; $display("FAIL alu_opcode: got %b, required %b", opc32, OP_ALU); end
    @(negedge clk);
    n_vec++;
    if (wbv32 !== 1'b0 || r32 !== 1'b1) begin
      n_err++;
      $display("FAIL alu_pulse: wb_valid %b ready %b, required 0 1", wbv32, r32);
    end
    sb.push_back(mk(1'b1, 5'd1, 64'h104, 1'b0, 2'd0));
    send(0, OP_J, 3'b000, 64'h5555, 64'h0, 64'h100, 5'd1);
    wait_wb(0, 1, got, lat);
    exp = sb.pop_front();
    n_vec += 2;
    if (lat != 1) begin n_err++; $display("FAIL jal_latency: wb at T+%0d, required T+1", lat); end
    if (got !== exp) begin n_err++; $display("FAIL jal_wb: got %h, required %h", got, exp); end
  endtask

  task automatic test_lb();
    wb_t got, exp;
    int  lat;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(mk(1'b1, 5'd7, (k == 0) ? 64'hFFFF_FF80 : 64'h80, 1'b0, 2'd0));
      send(0, OP_LD, (k == 0) ? 3'b000 : 3'b100, 64'h1003, 64'h0, 64'h0, 5'd7);
      n_vec++;
      if ({dv32, we32, sel32, daddr32, fbusy32, frd32} !== {1'b1, 1'b0, 4'b1000, 32'h1000, 1'b1, 5'd7}) begin
        n_err++;
        $display("FAIL lb_request: dv %b wr %b sel %b addr %h busy %b frd %0d, required 1 0 1000 00001000 1 7",
                 dv32, we32, sel32, daddr32, fbusy32, frd32);
      end
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      n_vec++;
      if (dv32 !== 1'b0 || fbusy32 !== 1'b1) begin
        n_err++;
        $display("FAIL lb_wait: dv %b busy %b, required 0 1", dv32, fbusy32);
      end
      d_rvalid = 1'b1;
      rdata = 64'h8000_0000;
      @(negedge clk);
      d_rvalid = 1'b0;
      wait_wb(0, 3, got, lat);
      exp = sb.pop_front();
      n_vec += 3;
      if (lat != 3) begin n_err++; $display("FAIL lb_latency: wb at T+%0d, required T+3", lat); end
      if (got !== exp) begin n_err++; $display("FAIL lb_wb: got %h, required %h", got, exp); end
      if (fbusy32 !== 1'b0) begin n_err++; $display("FAIL lb_fwd_clear: busy %b, required 0", fbusy32); end
    end
  endtask

  task automatic test_sh_delayed();
    wb_t got, exp;
    int  lat;
    sb.push_back(mk(1'b0, 5'd9, 64'h0, 1'b0, 2'd0));
    send(0, OP_S, 3'b001, 64'h2002, 64'hFFFF_ABCD, 64'h0, 5'd9);
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if ({dv32, we32, sel32, daddr32, wdata32, fbusy32} !==
          {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCD_0000, 1'b0}) begin
        n_err++;
        $display("FAIL sh_hold c%0d: dv %b wr %b sel %b addr %h wdata %h busy %b, required 1 1 1100 00002000 abcd0000 0",
                 c, dv32, we32, sel32, daddr32, wdata32, fbusy32);
      end
      d_rvalid = (c == 1);
      d_error  = (c == 1);
      rdata    = 64'h5A5A_5A5A;
      if (c == 3) d_ready = 1'b1;
      @(negedge clk);
    end
    d_ready  = 1'b0;
    d_error  = 1'b0;
    d_rvalid = 1'b1;
    @(negedge clk);
    d_rvalid = 1'b0;
    wait_wb(0, 6, got, lat);
    exp = sb.pop_front();
    n_vec += 2;
    if (lat != 6) begin n_err++; $display("FAIL sh_latency: wb at T+%0d, required T+6", lat); end
    if (got !== exp) begin n_err++; $display("FAIL sh_wb: got %h, required %h", got, exp); end
  endtask

  task automatic test_misaligned();
    wb_t got, exp;
    int  lat;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [1:0]  cause;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       begin op = OP_LD; f3 = 3'b010; addr = 64'h3002; cause = 2'd0; end
        1:       begin op = OP_S;  f3 = 3'b010; addr = 64'h3001; cause = 2'd1; end
        2:       begin op = OP_LD; f3 = 3'b011; addr = 64'h3000; cause = 2'd0; end
        default: begin op = OP_LD; f3 = 3'b110; addr = 64'h3004; cause = 2'd0; end
      endcase
      sb.push_back(mk(1'b0, 5'd4, addr, 1'b1, cause));
      send(0, op, f3, addr, 64'h1, 64'h0, 5'd4);
      n_vec++;
      if (dv32 !== 1'b0) begin n_err++; $display("FAIL mis_no_bus k%0d: o_d_valid %b, required 0", k, dv32); end
      wait_wb(0, 1, got, lat);
      exp = sb.pop_front();
      n_vec += 2;
      if (lat != 1) begin n_err++; $display("FAIL mis_latency k%0d: wb at T+%0d, required T+1", k, lat); end
      if (got !== exp) begin n_err++; $display("FAIL mis_wb k%0d: got %h, required %h", k, got, exp); end
    end
  endtask

  task automatic test_timeout_and_error();
    wb_t got, exp;
    int  lat;
    for (int k = 0; k < 2; k++) begin
      sb.push_back((k == 0) ? mk(1'b0, 5'd3, 64'h4000, 1'b1, 2'd2) : mk(1'b1, 5'd6, 64'hDEAD_BEEF, 1'b0, 2'd0));
      send(0, OP_LD, 3'b010, (k == 0) ? 64'h4000 : 64'h6000, 64'h0, 64'h0, (k == 0) ? 5'd3 : 5'd6);
      d_ready = 1'b1;
      @(negedge clk);
      d_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (wbv32 !== 1'b0 || fbusy32 !== 1'b1) begin
        n_err++;
        $display("FAIL to_early k%0d: wb_valid %b busy %b in 4th WAIT cycle, required 0 1", k, wbv32, fbusy32);
      end
      if (k == 1) begin
        d_rvalid = 1'b1;
        rdata = 64'hDEAD_BEEF;
      end
      @(negedge clk);
      d_rvalid = 1'b0;
      wait_wb(0, 6, got, lat);
      exp = sb.pop_front();
      n_vec += 2;
      if (lat != 6) begin n_err++; $display("FAIL to_latency k%0d: wb at T+%0d, required T+6", k, lat); end
      if (got !== exp) begin n_err++; $display("FAIL to_wb k%0d: got %h, required %h", k, got, exp); end
    end
    sb.push_back(mk(1'b0, 5'd8, 64'h5002, 1'b1, 2'd2));
    send(0, OP_LD, 3'b001, 64'h5002, 64'h0, 64'h0, 5'd8);
    d_ready = 1'b1;
    @(negedge clk);
    d_ready  = 1'b0;
    d_rvalid = 1'b1;
    d_error  = 1'b1;
    @(negedge clk);
    d_rvalid = 1'b0;
    d_error  = 1'b0;
    wait_wb(0, 3, got, lat);
    exp = sb.pop_front();
    n_vec += 2;
    if (lat != 3) begin n_err++; $display("FAIL err_latency: wb at T+%0d, required T+3", lat); end
    if (got !== exp) begin n_err++; $display("FAIL err_wb: got %h, required %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    send(0, OP_LD, 3'b010, 64'h7000, 64'h0, 64'h0, 5'd10);
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({dv32, wbv32, fbusy32} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_outputs: dv %b wb %b busy %b, required 000", dv32, wbv32, fbusy32);
    end
    d_rvalid = 1'b1;
    rdata = 64'h1111_2222;
    @(negedge clk);
    d_rvalid = 1'b0;
    n_vec++;
    if (r32 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: o_ready %b, required 1", r32); end
    for (int c = 0; c < 4; c++) begin
      if (wbv32 === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_stray: wb_valid seen %b, required 0", seen); end
  endtask

  task automatic test_back_to_back();
    wb_t got, exp;
    int  lat;
    sb.push_back(mk(1'b0, 5'd2, 64'h0, 1'b0, 2'd0));
    send(0, OP_S, 3'b010, 64'h2000, 64'h1122_3344, 64'h0, 5'd2);
    n_vec++;
    if ({sel32, wdata32, we32} !== {4'b1111, 32'h1122_3344, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_store_req: sel %b wdata %h wr %b, required 1111 11223344 1", sel32, wdata32, we32);
    end
    d_ready = 1'b1;
    @(negedge clk);
    d_ready  = 1'b0;
    d_rvalid = 1'b1;
    @(negedge clk);
    d_rvalid = 1'b0;
    wait_wb(0, 3, got, lat);
    exp = sb.pop_front();
    n_vec += 2;
    if (lat != 3) begin n_err++; $display("FAIL b2b_store_latency: wb at T+%0d, required T+3", lat); end
    if (got !== exp) begin n_err++; $display("FAIL b2b_store_wb: got %h, required %h", got, exp); end
    @(negedge clk);
    n_vec++;
    if (r32 !== 1'b1) begin n_err++; $display("FAIL b2b_ready: o_ready %b after RESP, required 1", r32); end
    sb.push_back(mk(1'b0, 5'd0, 64'h99, 1'b0, 2'd0));
    send(0, OP_ALU, 3'b000, 64'h99, 64'h0, 64'h0, 5'd0);
    wait_wb(0, 1, got, lat);
    exp = sb.pop_front();
    n_vec += 2;
    if (lat != 1) begin n_err++; $display("FAIL b2b_alu_latency: wb at T+%0d, required T+1", lat); end
    if (got !== exp) begin n_err++; $display("FAIL b2b_alu_wb: got %h, required %h", got, exp); end
  endtask

  task automatic test_xlen64();
    wb_t got, exp;
    int  lat;
    logic [2:0]  f3;
    logic [63:0] addr, rd_val, wb_val;
    logic [7:0]  sel;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin f3 = 3'b011; addr = 64'h8; rd_val = 64'h0123_4567_89AB_CDEF;
                       wb_val = 64'h0123_4567_89AB_CDEF; sel = 8'hFF; end
        1:       begin f3 = 3'b110; addr = 64'hC; rd_val = 64'h8765_4321_0000_0000;
                       wb_val = 64'h0000_0000_8765_4321; sel = 8'hF0; end
        default: begin f3 = 3'b010; addr = 64'hC; rd_val = 64'h8765_4321_0000_0000;
                       wb_val = 64'hFFFF_FFFF_8765_4321; sel = 8'hF0; end
      endcase
      sb.push_back(mk(1'b1, 5'(11 + k), wb_val, 1'b0, 2'd0));
      send(1, OP_LD, f3, addr, 64'h0, 64'h0, 5'(11 + k));
      n_vec++;
      if ({dv64, sel64, daddr64, fbusy64} !== {1'b1, sel, 64'h8, 1'b1}) begin
        n_err++;
        $display("FAIL x64_request k%0d: dv %b sel %h addr %h busy %b, required 1 %h 0000000000000008 1",
                 k, dv64, sel64, daddr64, fbusy64, sel);
      end
      d_ready = 1'b1;
      @(negedge clk);
      d_ready  = 1'b0;
      d_rvalid = 1'b1;
      rdata    = rd_val;
      @(negedge clk);
      d_rvalid = 1'b0;
      wait_wb(1, 3, got, lat);
      exp = sb.pop_front();
      n_vec += 2;
      if (lat != 3) begin n_err++; $display("FAIL x64_latency k%0d: wb at T+%0d, required T+3", k, lat); end
      if (got !== exp) begin n_err++; $display("FAIL x64_wb k%0d: got %h, required %h", k, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_sh_delayed();
    test_misaligned();
    test_timeout_and_error();
    test_reset_mid();
    test_back_to_back();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
